div_unit: RTL and testbench

Iterative 32-bit divider implementing the RV32M DIV, DIVU, REM and REMU operations. It sits in the EX stage beside the ALU and takes the same `data1`/`data2` operand buses from the ID/EX register. Its `result` is muxed with the ALU result into the EX/MEM register. While `busy` is high the hazard unit stalls IF/ID/EX.

---
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_EXIT_EN: divide-by-zero and signed overflow finish in 2 cycles instead of 33.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [1:0]       func,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic [4:0]       cnt;
    logic             qsign;
    logic             rsign;
    logic [1:0]       func_q;
    logic             dz;
`ifdef DIV_EARLY_EXIT_EN
    logic             early_q;
`endif

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic             neg;
    logic [WIDTH-1:0] fixed;

    assign busy = (state != IDLE);

    always_comb begin
        a_neg   = ~func[0] & data1[WIDTH-1];
        b_neg   = ~func[0] & data2[WIDTH-1];
        abs_a   = a_neg ? -data1 : data1;
        abs_b   = b_neg ? -data2 : data2;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        raw     = func_q[1] ? rem : quo;
        neg     = ~func_q[0] & (func_q[1] ? rsign : qsign);
        fixed   = neg ? -raw : raw;
        // Signed DIV by zero would otherwise pick up the dividend's sign.
        if (func_q == 2'b00 && dz)
            fixed = '1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            cnt     <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            func_q  <= 2'b00;
            dz      <= 1'b0;
            valid   <= 1'b0;
            result  <= '0;
`ifdef DIV_EARLY_EXIT_EN
            early_q <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo    <= abs_a;
                        rem    <= '0;
                        dvsr   <= abs_b;
                        cnt    <= 5'd31;
                        qsign  <= ~func[0] & (data1[WIDTH-1] ^ data2[WIDTH-1]);
                        rsign  <= ~func[0] & data1[WIDTH-1];
                        func_q <= func;
                        dz     <= (data2 == '0);
                        state  <= CALC;
`ifdef DIV_EARLY_EXIT_EN
                        // Preload the values the full iteration would have produced.
                        if (data2 == '0) begin
                            quo     <= '1;
                            rem     <= abs_a;
                            early_q <= 1'b1;
                        end else if (!func[0] && data1 == {1'b1, {(WIDTH-1){1'b0}}} && data2 == '1) begin
                            quo     <= abs_a;
                            rem     <= '0;
                            early_q <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
`ifdef DIV_EARLY_EXIT_EN
                    if (early_q) begin
                        early_q <= 1'b0;
                        state   <= DONE;
                    end else begin
`endif
                        if (!diff[WIDTH]) begin
                            rem <= diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0)
                            state <= DONE;
`ifdef DIV_EARLY_EXIT_EN
                    end
`endif
                end
                DONE: begin
                    result <= fixed;
                    valid  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table of signed/unsigned ops plus busy-start, back-to-back and reset-abort sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [1:0]  func;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .data1  (data1),
        .data2  (data2),
        .func   (func),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
        if (b == 32'h0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))
            return 2;
`endif
        return 33;
    endfunction

    // Accept at the next edge; return edges from acceptance until valid is seen.
    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        @(negedge clk);
        start = 1'b1; func = f; data1 = a; data2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        data1 = 32'hDEADBEEF; data2 = 32'h12345678; func = ~f;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (valid) break;
        end
        chk("valid_seen", {31'd0, valid}, 32'd1);
        chk("busy_low_at_valid", {31'd0, busy}, 32'd0);
        r = result;
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        int          vcount;

        vt[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
        vt[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
        vt[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
        vt[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
        vt[4]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
        vt[5]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1};
        vt[6]  = '{2'b00, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF};
        vt[7]  = '{2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
        vt[8]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        vt[9]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0};
        vt[10] = '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF};
        vt[11] = '{2'b11, 32'd5,          32'd0,          32'd5};
        vt[12] = '{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14};
        vt[13] = '{2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE};
        vt[14] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0};
        vt[15] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};

        reset_n = 1'b0; start = 1'b0; data1 = '0; data2 = '0; func = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vt[i].f, vt[i].a, vt[i].b, r, lat);
            chk($sformatf("vec%0d_result", i), r, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vt[i].f, vt[i].a, vt[i].b));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid_one_cycle", i), {31'd0, valid}, 32'd0);
        end

        // Start pulse while busy must be ignored; then back-to-back start in the valid cycle.
        @(negedge clk);
        start = 1'b1; func = 2'b01; data1 = 32'd1000; data2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) begin
                start = 1'b1; func = 2'b11; data1 = 32'd50; data2 = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (valid) break;
        end
        chk("busy_start_ignored_result", result, 32'd333);
        chk("busy_start_ignored_latency", lat, 33);
        start = 1'b1; func = 2'b01; data1 = 32'd77; data2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (valid) break;
        end
        chk("b2b_result", result, 32'd11);
        chk("b2b_latency", lat, 33);

        // Reset at cycle 10 of an operation aborts it with no valid pulse.
        @(negedge clk);
        start = 1'b1; func = 2'b01; data1 = 32'd1000; data2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        reset_n = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) vcount++;
        end
        chk("abort_no_valid", vcount, 0);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
